// File: rtl/key_arbiter_pkg.sv
// Shared key codes, parameter defaults and the fixed-priority grant helper
// for the key debounce/arbiter block.
package key_arbiter_pkg;

  localparam int NUM_KEYS       = 5;
  localparam int DEB_CYCLES_DEF = 1000000;
  localparam int RPT_DELAY_DEF  = 25000000;
  localparam int RPT_PERIOD_DEF = 10000000;

  localparam logic [4:0] KEY_NONE  = 5'b00000;
  localparam logic [4:0] KEY_LEFT  = 5'b00001;
  localparam logic [4:0] KEY_RIGHT = 5'b00010;
  localparam logic [4:0] KEY_SUB   = 5'b00100;
  localparam logic [4:0] KEY_ADD   = 5'b01000;
  localparam logic [4:0] KEY_MODE  = 5'b10000;

  // Only the cursor keys auto-repeat.
  localparam logic [4:0] RPT_MASK = KEY_LEFT | KEY_RIGHT;

  // Highest-priority pending key wins: mode > add > sub > right > left.
  function automatic logic [4:0] prio_grant(input logic [4:0] pend);
    logic [4:0] g;
    g = KEY_NONE;
    if (pend[4]) begin
      g = KEY_MODE;
    end else if (pend[3]) begin
      g = KEY_ADD;
    end else if (pend[2]) begin
      g = KEY_SUB;
    end else if (pend[1]) begin
      g = KEY_RIGHT;
    end else if (pend[0]) begin
      g = KEY_LEFT;
    end else begin
      g = KEY_NONE;
    end
    return g;
  endfunction

endpackage

// File: rtl/key_arbiter_if.sv
// Key bus between the push-button front end and the edit controller.
interface key_arbiter_if;

  logic [4:0] key_raw;
  logic [4:0] key_out;
  logic [4:0] pend_out;

  modport master (output key_raw, input key_out, input pend_out);
  modport slave  (input key_raw, output key_out, output pend_out);

endinterface

// File: rtl/key_debounce.sv
// One-key front end: 2-flop synchronizer, consecutive-sample debounce counter,
// debounced level and a registered single-cycle rise strobe.
module key_debounce
  import key_arbiter_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample agreeing with the current level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = {CW{1'b0}};
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = ~level_q;
        cnt_d   = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
    rise_d = level_d & ~level_q;
  end

  // Synchronizer and debounce state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/key_arbiter.sv
// Five debounced keys feeding a pending-event register with cursor auto-repeat
// and a fixed-priority arbiter emitting one registered one-hot event per cycle.
module key_arbiter
  import key_arbiter_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int RPT_DELAY  = RPT_DELAY_DEF,
  parameter int RPT_PERIOD = RPT_PERIOD_DEF
) (
  input  logic          clk,
  input  logic          clr,
  key_arbiter_if.slave  bus
);

  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);

  logic [NUM_KEYS-1:0]         level_s, rise_s, fire_s, set_s, grant_s;
  logic [NUM_KEYS-1:0]         pend_q, pend_d, key_out_q, key_out_d;
  logic [NUM_KEYS-1:0]         armed_q, armed_d;
  logic [NUM_KEYS-1:0][RW-1:0] rpt_cnt_q, rpt_cnt_d;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_deb
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .clr   (clr),
      .raw   (bus.key_raw[i]),
      .level (level_s[i]),
      .rise  (rise_s[i])
    );
  end

  // Repeat timers count from the press strobe; armed selects delay vs period.
  // Non-repeating keys hold their timers at zero so they reduce to constants.
  always_comb begin
    rpt_cnt_d = '0;
    armed_d   = '0;
    fire_s    = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!level_s[i] || !RPT_MASK[i]) begin
        rpt_cnt_d[i] = {RW{1'b0}};
        armed_d[i]   = 1'b0;
      end else if (rise_s[i]) begin
        rpt_cnt_d[i] = RW'(1);
        armed_d[i]   = 1'b0;
      end else if (rpt_cnt_q[i] == (armed_q[i] ? RW'(RPT_PERIOD) : RW'(RPT_DELAY))) begin
        fire_s[i]    = 1'b1;
        rpt_cnt_d[i] = RW'(1);
        armed_d[i]   = 1'b1;
      end else begin
        rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
        armed_d[i]   = armed_q[i];
      end
    end
  end

  // A set arriving in the grant cycle survives the clear.
  always_comb begin
    set_s     = rise_s | fire_s;
    grant_s   = prio_grant(pend_q);
    pend_d    = (pend_q & ~grant_s) | set_s;
    key_out_d = grant_s;
  end

  // Pending, output and repeat state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pend_q    <= '0;
      key_out_q <= '0;
      armed_q   <= '0;
      rpt_cnt_q <= '0;
    end else begin
      pend_q    <= pend_d;
      key_out_q <= key_out_d;
      armed_q   <= armed_d;
      rpt_cnt_q <= rpt_cnt_d;
    end
  end

  assign bus.key_out  = key_out_q;
  assign bus.pend_out = pend_q;

endmodule

// File: tb/tb_key_arbiter.sv
// Directed bench for key_arbiter with a cycle-stamped scoreboard of expected key events.
module tb_key_arbiter;
  import key_arbiter_pkg::*;

  typedef struct {
    int         cyc;
    logic [4:0] code;
  } exp_t;

  logic clk = 1'b0;
  logic clr;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  key_arbiter_if bus();

  key_arbiter #(.DEB_CYCLES(4), .RPT_DELAY(20), .RPT_PERIOD(8)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic expect_at(input int delay, input logic [4:0] code);
    exp_t e;
    e.cyc  = cyc + delay;
    e.code = code;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    vectors++;
    assert ((bus.key_out & (bus.key_out - 5'd1)) === 5'b00000) else begin
      miscompares++;
      $error("FAIL onehot cyc=%0d observed=%b expected=at most one bit set", cyc, bus.key_out);
    end
    vectors++;
    if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      assert (bus.key_out === e.code) else begin
        miscompares++;
        $error("FAIL event cyc=%0d observed=%b expected=%b", cyc, bus.key_out, e.code);
      end
    end else begin
      assert (bus.key_out === KEY_NONE) else begin
        miscompares++;
        $error("FAIL idle cyc=%0d observed=%b expected=%b", cyc, bus.key_out, KEY_NONE);
      end
    end
  endtask

  task automatic check_pend(input string tag, input logic [4:0] exp_v);
    vectors++;
    assert (bus.pend_out === exp_v) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, bus.pend_out, exp_v);
    end
  endtask

  initial begin
    clr         = 1'b1;
    bus.key_raw = 5'b00000;
    repeat (2) tick();
    check_pend("reset_pend", 5'b00000);
    clr = 1'b0;
    repeat (4) tick();

    // Clean press of increment, held 10 samples
    bus.key_raw = KEY_ADD;
    expect_at(8, KEY_ADD);
    repeat (10) tick();
    bus.key_raw = 5'b00000;
    repeat (20) tick();

    // Decrement bounces 1,0,1,0 then steady high
    bus.key_raw = KEY_SUB;  tick();
    bus.key_raw = 5'b00000; tick();
    bus.key_raw = KEY_SUB;  tick();
    bus.key_raw = 5'b00000; tick();
    bus.key_raw = KEY_SUB;
    expect_at(8, KEY_SUB);
    repeat (12) tick();
    bus.key_raw = 5'b00000;
    repeat (20) tick();

    // Left, add and mode rise together: emitted in priority order
    bus.key_raw = 5'b11001;
    expect_at(8, KEY_MODE);
    expect_at(9, KEY_ADD);
    expect_at(10, KEY_LEFT);
    repeat (7) tick();
    check_pend("simul_pend", 5'b11001);
    repeat (3) tick();
    bus.key_raw = 5'b00000;
    repeat (20) tick();

    // Cursor-right held 50 samples: press plus four repeats
    bus.key_raw = KEY_RIGHT;
    expect_at(8, KEY_RIGHT);
    expect_at(28, KEY_RIGHT);
    expect_at(36, KEY_RIGHT);
    expect_at(44, KEY_RIGHT);
    expect_at(52, KEY_RIGHT);
    repeat (50) tick();
    bus.key_raw = 5'b00000;
    repeat (30) tick();

    // Mode held 50 samples: no repeat
    bus.key_raw = KEY_MODE;
    expect_at(8, KEY_MODE);
    repeat (50) tick();
    bus.key_raw = 5'b00000;
    repeat (20) tick();

    // Reset with add/mode pending and left held; only left re-debounces
    bus.key_raw = 5'b11001;
    repeat (7) tick();
    check_pend("pre_clr_pend", 5'b11001);
    clr         = 1'b1;
    bus.key_raw = KEY_LEFT;
    #1;
    check_pend("clr_pend", 5'b00000);
    vectors++;
    assert (bus.key_out === KEY_NONE) else begin
      miscompares++;
      $error("FAIL clr_out cyc=%0d observed=%b expected=%b", cyc, bus.key_out, KEY_NONE);
    end
    repeat (2) tick();
    clr = 1'b0;
    expect_at(8, KEY_LEFT);
    repeat (10) tick();
    bus.key_raw = 5'b00000;
    repeat (20) tick();

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL drain observed=%0d expected=0 outstanding events", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
